// File: rtl/clk_div_prog.sv
// Programmable divide-by-N clock divider (N = 2..2^CNT_W-1) with enable, boundary-aligned divisor load and per-period tick.
// Optional build macro CLK_DIV_ODD_50_EN adds a negedge flop so odd N yields 50% duty.
module clk_div_prog #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_ready,
    output logic             div_err,
    output logic [CNT_W-1:0] div_cur,
    output logic             clk_out,
    output logic             tick
);
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             pos_q, pos_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic [CNT_W:0]   half;
    logic             boundary, ld_ok, ld_bad;

    // Threshold is one bit wider so divisor 2^CNT_W-1 does not overflow.
    assign half     = ({1'b0, div_cur_q} + 1'b1) >> 1;
    assign cnt_inc  = cnt_q + 1'b1;
    assign boundary = (cnt_q == div_cur_q - 1'b1);
    assign ld_ok    = div_load && !pend_q && (div_in >= MIN_DIV);
    assign ld_bad   = div_load && !pend_q && (div_in <  MIN_DIV);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_cur_q  <= DEF_DIV;
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            pos_q      <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            pos_q      <= pos_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        pos_d      = pos_q;
        tick_d     = 1'b0;
        err_d      = ld_bad;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                pos_d = 1'b0;
                if (en) begin
                    if (pend_q) begin
                        div_cur_d = div_pend_q;
                        pend_d    = 1'b0;
                    end
                    state_d = RUN;
                    pos_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            default: begin
                if (boundary) begin
                    if (pend_q) begin
                        div_cur_d = div_pend_q;
                        pend_d    = 1'b0;
                    end
                    cnt_d = '0;
                    if (en) begin
                        pos_d  = 1'b1;
                        tick_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        pos_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    pos_d = ({1'b0, cnt_inc} < half);
                end
            end
        endcase
        // Capture after any apply above, so a same-cycle load waits for the next boundary.
        if (ld_ok) begin
            div_pend_d = div_in;
            pend_d     = 1'b1;
        end
    end

`ifdef CLK_DIV_ODD_50_EN
    logic neg_q;
    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) neg_q <= 1'b0;
        else        neg_q <= pos_q;
    end
    // Select only changes at a boundary, so the mux switch cannot glitch.
    assign clk_out = div_cur_q[0] ? (pos_q & neg_q) : pos_q;
`else
    assign clk_out = pos_q;
`endif

    assign div_ready = ~pend_q;
    assign div_err   = err_q;
    assign div_cur   = div_cur_q;
    assign tick      = tick_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: duty/period via half-cycle sampling, load handshake, enable stop/start, async reset.
module tb_clk_div_prog;
    localparam int CNT_W = 8;
`ifdef CLK_DIV_ODD_50_EN
    localparam int ODD50 = 1;
`else
    localparam int ODD50 = 0;
`endif

    logic             clk_in = 1'b0;
    logic             rst_n  = 1'b1;
    logic             en     = 1'b0;
    logic [CNT_W-1:0] div_in = '0;
    logic             div_load = 1'b0;
    logic             div_ready, div_err, clk_out, tick;
    logic [CNT_W-1:0] div_cur;

    int n_cmp = 0;
    int n_err = 0;
    int hi, tk, cyc;

    clk_div_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(3)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .en(en), .div_in(div_in), .div_load(div_load),
        .div_ready(div_ready), .div_err(div_err), .div_cur(div_cur),
        .clk_out(clk_out), .tick(tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // High half-cycles per period: N for even N or 50% odd build, 2*H otherwise.
    function automatic int hi_exp(input int n);
        if (n % 2 == 0) return n;
        return (ODD50 != 0) ? n : n + 1;
    endfunction

    // Advance posedge by posedge until tick is seen; returns cycles taken.
    task automatic wait_tick(output int c);
        c = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk_in); #1;
            c++;
            if (tick) return;
        end
        chk("tick_timeout", 0, 1);
    endtask

    // Starting at the tick sample, take 2n half-cycle samples (one period).
    task automatic measure(input int n, input int drop, output int h, output int t);
        h = int'(clk_out);
        t = int'(tick);
        for (int i = 1; i < 2 * n; i++) begin
            if (i % 2 == 1) begin
                @(negedge clk_in); #1;
            end else begin
                @(posedge clk_in); #1;
                t += int'(tick);
            end
            if (i == drop) en = 1'b0;
            h += int'(clk_out);
        end
    endtask

    task automatic load(input int v);
        div_in = CNT_W'(v); div_load = 1'b1;
        @(posedge clk_in); #1;
        div_load = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_div_err", div_err, 0);
        chk("rst_div_ready", div_ready, 1);
        chk("rst_div_cur", div_cur, 3);
        @(negedge clk_in); rst_n = 1'b1;
        @(negedge clk_in); en = 1'b1;

        // Default N=3
        wait_tick(cyc);
        chk("start_cyc", cyc, 1);
        for (int p = 0; p < 2; p++) begin
            measure(3, -1, hi, tk);
            chk("n3_hi", hi, hi_exp(3));
            chk("n3_tick", tk, 1);
            wait_tick(cyc);
            chk("n3_period", cyc, 1);
        end
        chk("n3_div_cur", div_cur, 3);

        // Load 4 at cnt=0: current 3-cycle period completes first
        load(4);
        chk("ld4_ready_low", div_ready, 0);
        chk("ld4_div_cur_old", div_cur, 3);
        wait_tick(cyc);
        chk("ld4_latency", cyc, 2);
        chk("ld4_div_cur", div_cur, 4);
        chk("ld4_ready_high", div_ready, 1);
        measure(4, -1, hi, tk);
        chk("n4_hi", hi, hi_exp(4));
        chk("n4_tick", tk, 1);
        wait_tick(cyc);
        chk("n4_period", cyc, 1);

        // Illegal divisors
        load(1);
        chk("err1_pulse", div_err, 1);
        @(posedge clk_in); #1;
        chk("err1_clear", div_err, 0);
        load(0);
        chk("err0_pulse", div_err, 1);
        chk("err0_ready", div_ready, 1);
        @(posedge clk_in); #1;
        chk("err0_clear", div_err, 0);
        chk("err_div_cur", div_cur, 4);

        // N=5, then drop en at cnt=1
        load(5);
        wait_tick(cyc);
        chk("ld5_div_cur", div_cur, 5);
        measure(5, -1, hi, tk);
        chk("n5_hi", hi, hi_exp(5));
        wait_tick(cyc);
        measure(5, 2, hi, tk);
        chk("drop_hi", hi, hi_exp(5));
        chk("drop_tick", tk, 1);
        measure(6, -1, hi, tk);
        chk("idle_hi", hi, 0);
        chk("idle_tick", tk, 0);
        en = 1'b1;
        @(posedge clk_in); #1;
        chk("restart_tick", tick, 1);
        @(negedge clk_in); #1;
        chk("restart_clk_out", clk_out, 1);

        // Load 6, second load while pending is ignored
        @(posedge clk_in); #1;
        load(6);
        div_in = CNT_W'(9); div_load = 1'b1;
        @(posedge clk_in); #1;
        div_load = 1'b0;
        chk("ignored_no_err", div_err, 0);
        wait_tick(cyc);
        chk("ld6_div_cur", div_cur, 6);
        wait_tick(cyc);
        chk("n6_period", cyc, 6);
        chk("n6_div_cur_kept", div_cur, 6);
        chk("n6_ready", div_ready, 1);

        // Async reset in high phase
        @(negedge clk_in); #1;
        chk("n6_high_before_rst", clk_out, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_clk_out", clk_out, 0);
        chk("midrst_tick", tick, 0);
        chk("midrst_div_cur", div_cur, 3);
        chk("midrst_ready", div_ready, 1);
        @(negedge clk_in); rst_n = 1'b1;
        wait_tick(cyc);
        measure(3, -1, hi, tk);
        chk("post_rst_hi", hi, hi_exp(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
